// File: rtl/digit_scan_ctrl.sv
// Multiplexed 4-digit display scanner: walks a 2-to-4 decoder through the digits
// with a blanking gap before each one, and swaps in newly loaded data only at frame boundaries.
module digit_scan_ctrl #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [15:0] DATA,
  output logic        G_L,
  output logic        A,
  output logic        B,
  output logic [3:0]  DIGIT,
  output logic        FRAME_DONE,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [15:0] BLANK_LD = 16'(BLANK - 1);
  localparam logic [15:0] DWELL_LD = 16'(DWELL - 1);

  logic [1:0]  state, nxt_state;
  logic [15:0] cnt, nxt_cnt;
  logic [1:0]  idx, nxt_idx;
  logic [15:0] display, nxt_display;
  logic [15:0] pending, nxt_pending;
  logic        pend_flag, nxt_pend_flag;
  logic        frame_end;
  logic        ab_upd;
  logic [3:0]  nxt_digit;

  assign dbg_state = state;

  // Counter holds (cycles remaining - 1) and is reloaded on every state entry.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (EN) begin
          nxt_state = S_BLANK;
          nxt_idx   = 2'd0;
          nxt_cnt   = BLANK_LD;
        end
      end
      S_BLANK: begin
        if (cnt == 16'd0) begin
          nxt_state = S_SHOW;
          nxt_cnt   = DWELL_LD;
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      S_SHOW: begin
        if (cnt == 16'd0) begin
          if (idx == 2'd3) begin
            frame_end = 1'b1;
            nxt_idx   = 2'd0;
            nxt_state = EN ? S_BLANK : S_IDLE;
            nxt_cnt   = EN ? BLANK_LD : 16'd0;
          end else begin
            nxt_idx   = idx + 2'd1;
            nxt_state = S_BLANK;
            nxt_cnt   = BLANK_LD;
          end
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = 16'd0;
        nxt_idx   = 2'd0;
      end
    endcase
  end

  // Display only changes in IDLE or on the frame-end edge, so a frame never mixes old and new digits.
  always_comb begin
    nxt_display   = display;
    nxt_pending   = pending;
    nxt_pend_flag = pend_flag;
    if (state == S_IDLE) begin
      if (LOAD) nxt_display = DATA;
    end else if (frame_end) begin
      if (LOAD) begin
        nxt_display   = DATA;
        nxt_pend_flag = 1'b0;
      end else if (pend_flag) begin
        nxt_display   = pending;
        nxt_pend_flag = 1'b0;
      end
    end else if (LOAD) begin
      nxt_pending   = DATA;
      nxt_pend_flag = 1'b1;
    end
  end

  always_comb begin
    nxt_digit = nxt_display[3:0];
    case (nxt_idx)
      2'd0: nxt_digit = nxt_display[3:0];
      2'd1: nxt_digit = nxt_display[7:4];
      2'd2: nxt_digit = nxt_display[11:8];
      2'd3: nxt_digit = nxt_display[15:12];
      default: nxt_digit = nxt_display[3:0];
    endcase
  end

  // Select lines move only on the edge entering BLANK or IDLE, never while the decoder is enabled.
  assign ab_upd = (nxt_state != S_SHOW) && (nxt_state != state);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= 16'd0;
      idx        <= 2'd0;
      display    <= 16'd0;
      pending    <= 16'd0;
      pend_flag  <= 1'b0;
      G_L        <= 1'b1;
      A          <= 1'b0;
      B          <= 1'b0;
      DIGIT      <= 4'd0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      idx        <= nxt_idx;
      display    <= nxt_display;
      pending    <= nxt_pending;
      pend_flag  <= nxt_pend_flag;
      G_L        <= (nxt_state != S_SHOW);
      FRAME_DONE <= frame_end;
      if (ab_upd) begin
        A     <= nxt_idx[0];
        B     <= nxt_idx[1];
        DIGIT <= nxt_digit;
      end
    end
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 1000: cycles G_L is held low per digit; legal range 1..65535.
REQ-002 Parameter BLANK, default 16: cycles G_L is held high before each digit; legal range 1..65535.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 EN  input  1  scan enable, sampled only in IDLE and at frame end.
REQ-006 LOAD  input  1  single-cycle strobe that captures DATA.
REQ-007 DATA  input  16  four 4-bit digit codes; digit n occupies DATA[4n+3:4n].
REQ-008 G_L  output  1  active-low enable to the downstream 2-to-4 decoder; registered.
REQ-009 A  output  1  decoder select LSB (digit index bit 0); registered.
REQ-010 B  output  1  decoder select MSB (digit index bit 1); registered.
REQ-011 DIGIT  output  4  code of the currently selected digit; registered.
REQ-012 FRAME_DONE  output  1  one-cycle pulse at the end of each completed 4-digit frame; registered.

Function
REQ-013 States SHALL be IDLE, BLANK and SHOW; G_L=1 in IDLE and BLANK, G_L=0 in SHOW.
REQ-014 IDLE: A=B=0; if EN=1, next state BLANK with index 0; otherwise remain IDLE.
REQ-015 BLANK SHALL last exactly BLANK cycles, then go to SHOW with the same index.
REQ-016 SHOW SHALL last exactly DWELL cycles; at its end with index<3, index increments and the state goes to BLANK.
REQ-017 At SHOW end with index=3: FRAME_DONE=1 for the next cycle only; index wraps to 0; next state BLANK if EN=1, else IDLE.
REQ-018 EN deasserted mid-frame SHALL NOT truncate the frame; the frame completes and IDLE follows.
REQ-019 A and B SHALL change only on the edge that enters BLANK or IDLE, so that they never change while G_L=0.
REQ-020 Frame length SHALL be exactly 4*(BLANK+DWELL) cycles; the dwell/blank counter SHALL be 16 bits wide and reload on every state entry.
REQ-021 DIGIT SHALL equal display[4*idx+3:4*idx], where idx = {B,A}, updated together with A/B.
REQ-022 In IDLE, LOAD=1 SHALL write DATA directly into the display register.
REQ-023 Outside IDLE, LOAD=1 SHALL write DATA into a pending register and set a pending flag; a later LOAD overwrites it (last write wins).
REQ-024 At frame end (REQ-017), a set pending flag SHALL copy pending into display and clear the flag; a frame never shows mixed old/new digits.
REQ-025 LOAD in the frame-end cycle SHALL put that cycle's DATA into display directly, overriding any pending value.

Reset
REQ-026 RESET=1 SHALL immediately force: state IDLE, G_L=1, A=B=0, DIGIT=0, FRAME_DONE=0, display=0, pending=0, pending flag=0, counter=0.
REQ-027 RESET asserted mid-frame SHALL abort the frame with no FRAME_DONE pulse; after release, scanning restarts from IDLE per REQ-014.

Verification (DWELL=4, BLANK=2)
REQ-028 Reset, LOAD DATA=16'h4321 in IDLE, EN=1 -> G_L pattern HHLLLL per digit; {B,A}=0,1,2,3 with DIGIT=1,2,3,4; FRAME_DONE pulses once after 24 cycles.
REQ-029 Mid-frame LOAD 16'hABCD while 16'h4321 is displayed -> remaining digits of the frame show 3,4; the next frame shows D,C,B,A.
REQ-030 EN dropped during digit 1 -> digits 2 and 3 still shown, FRAME_DONE pulses, then G_L=1 and A=B=0 in IDLE.
REQ-031 Across the entire run, no A/B transition occurs in any cycle where G_L=0 (assertion check).
REQ-032 RESET asserted during SHOW of digit 2 -> G_L=1, A=B=0, DIGIT=0 within the same cycle; no FRAME_DONE pulse.
REQ-033 LOAD 16'h1111 and then 16'h2222 in the same frame, plus LOAD 16'h3333 in the frame-end cycle -> the next frame shows 3,3,3,3.
